// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//
// Watches the 4-bit output of an asynchronous ripple counter from a
// synchronous clock domain. The raw count is synchronized, debounced until it
// has been stable long enough, and each committed value is compared with the
// previous one. Legal single steps in the expected direction advance a 12-bit
// extended count; anything else is flagged as a step error.
//
// Parameters
//   STABLE_CYC   clk cycles a synchronized value must hold before it commits
//                (legal range 1..15)
//
// Ports
//   clk          single clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   cnt_in[3:0]  ripple-counter q outputs, asynchronous to clk, may glitch
//   up           expected direction (1 = up, 0 = down), sampled at commit
//   clr          synchronous clear, active-high, wins over a coincident commit
//   count_valid  a committed value exists
//   count_out    last committed cnt_in value
//   ext_count    extended count of legal steps, mod 4096
//   wrap         one-cycle pulse on a legal 15->0 (up) or 0->15 (down) step
//   step_err     one-cycle pulse on an illegal step

module ripple_count_monitor #(
  parameter int STABLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cnt_in,
  input  logic        up,
  input  logic        clr,
  output logic        count_valid,
  output logic [3:0]  count_out,
  output logic [11:0] ext_count,
  output logic        wrap,
  output logic        step_err
);

  // Saturation ceiling of the stability counter, and the value it holds on
  // the edge that commits. Committing one below the ceiling while the counter
  // still advances means a value that stays put commits exactly once.
  localparam logic [3:0] STAB_MAX    = 4'(STABLE_CYC);
  localparam logic [3:0] STAB_COMMIT = 4'(STABLE_CYC - 1);

  typedef enum logic {
    IDLE  = 1'b0,   // no reference value yet
    TRACK = 1'b1    // count_out holds a reference for step checking
  } state_e;

  // Synchronizer
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s2_q, s2_d;

  // Stability filter
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  stab_q, stab_d;
  logic        commit_s;

  // Tracker
  state_e      state_q, state_d;
  logic        count_valid_q, count_valid_d;
  logic [3:0]  count_out_q, count_out_d;
  logic [11:0] ext_count_q, ext_count_d;
  logic        wrap_q, wrap_d;
  logic        step_err_q, step_err_d;
  logic [3:0]  delta_s;

  // Synchronizer next state: it keeps shifting through clr.
  always_comb begin
    s1_d = cnt_in;
    s2_d = s1_q;
  end

  // Stability filter: restart on any change, otherwise count up to the
  // ceiling; clr reloads the candidate from the synchronizer.
  always_comb begin
    cand_d   = cand_q;
    stab_d   = stab_q;
    commit_s = 1'b0;
    if (clr) begin
      cand_d = s2_q;
      stab_d = 4'd0;
    end else if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = 4'd0;
    end else begin
      if (stab_q < STAB_MAX) begin
        stab_d = stab_q + 4'd1;
      end else begin
        stab_d = stab_q;
      end
      commit_s = (stab_q == STAB_COMMIT);
    end
  end

  // Step distance from the reference to the newly committed value, mod 16:
  // 1 is one step up, 15 is one step down.
  always_comb begin
    delta_s = cand_q - count_out_q;
  end

  // Tracker FSM next state and pulse outputs.
  always_comb begin
    state_d       = state_q;
    count_valid_d = count_valid_q;
    count_out_d   = count_out_q;
    ext_count_d   = ext_count_q;
    wrap_d        = 1'b0;
    step_err_d    = 1'b0;
    if (clr) begin
      state_d       = IDLE;
      count_valid_d = 1'b0;
      count_out_d   = 4'd0;
      ext_count_d   = 12'd0;
    end else if (commit_s) begin
      case (state_q)
        IDLE: begin
          // First value after reset/clear only establishes the reference.
          count_out_d   = cand_q;
          count_valid_d = 1'b1;
          state_d       = TRACK;
        end
        TRACK: begin
          if (cand_q != count_out_q) begin
            // Always resync, even on an illegal step, so one bad step does
            // not cascade into further errors.
            count_out_d = cand_q;
            if (up && (delta_s == 4'd1)) begin
              ext_count_d = ext_count_q + 12'd1;
              wrap_d      = (count_out_q == 4'd15);
            end else if (!up && (delta_s == 4'd15)) begin
              ext_count_d = ext_count_q - 12'd1;
              wrap_d      = (count_out_q == 4'd0);
            end else begin
              step_err_d  = 1'b1;
            end
          end else begin
            // Re-commit of the same value (e.g. after a glitch): nothing to do.
            count_out_d = count_out_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // All state registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= 4'd0;
      s2_q          <= 4'd0;
      cand_q        <= 4'd0;
      stab_q        <= 4'd0;
      state_q       <= IDLE;
      count_valid_q <= 1'b0;
      count_out_q   <= 4'd0;
      ext_count_q   <= 12'd0;
      wrap_q        <= 1'b0;
      step_err_q    <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      cand_q        <= cand_d;
      stab_q        <= stab_d;
      state_q       <= state_d;
      count_valid_q <= count_valid_d;
      count_out_q   <= count_out_d;
      ext_count_q   <= ext_count_d;
      wrap_q        <= wrap_d;
      step_err_q    <= step_err_d;
    end
  end

  assign count_valid = count_valid_q;
  assign count_out   = count_out_q;
  assign ext_count   = ext_count_q;
  assign wrap        = wrap_q;
  assign step_err    = step_err_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with STABLE_CYC = 2.
// A value applied right after an edge commits on the 5th edge that follows.

module tb_ripple_count_monitor;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cnt_in;
  logic        up;
  logic        clr;
  logic        count_valid;
  logic [3:0]  count_out;
  logic [11:0] ext_count;
  logic        wrap;
  logic        step_err;

  int n_cmp;
  int n_fail;
  int wrap_seen;
  int err_seen;
  int both_seen;
  int wrap_tick;
  int err_tick;

  ripple_count_monitor #(.STABLE_CYC(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_in      (cnt_in),
    .up          (up),
    .clr         (clr),
    .count_valid (count_valid),
    .count_out   (count_out),
    .ext_count   (ext_count),
    .wrap        (wrap),
    .step_err    (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    wrap_seen = 0;
    err_seen  = 0;
    both_seen = 0;
    wrap_tick = 0;
    err_tick  = 0;
  endtask

  // Apply v for n edges, recording pulses and the edge index they follow.
  task automatic hold(input logic [3:0] v, input int n);
    cnt_in = v;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (wrap)             begin wrap_seen++; wrap_tick = i; end
      if (step_err)         begin err_seen++;  err_tick  = i; end
      if (wrap && step_err) both_seen++;
    end
  endtask

  // One clr edge while presenting v, then keep v until it commits from IDLE.
  task automatic clear_and_load(input logic [3:0] v);
    clr    = 1'b1;
    cnt_in = v;
    tick();
    clr    = 1'b0;
    hold(v, 7);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    cnt_in = 4'd9;
    up     = 1'b1;
    clr    = 1'b0;
    #2;
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", count_valid); end
    n_cmp++; if (count_out !== 4'd0)   begin n_fail++; $display("FAIL rst_count_out: got %0d want 0", count_out); end
    n_cmp++; if (ext_count !== 12'd0)  begin n_fail++; $display("FAIL rst_ext: got %0d want 0", ext_count); end
    n_cmp++; if (wrap !== 1'b0)        begin n_fail++; $display("FAIL rst_wrap: got %b want 0", wrap); end
    n_cmp++; if (step_err !== 1'b0)    begin n_fail++; $display("FAIL rst_step_err: got %b want 0", step_err); end
    tick();
    tick();
    rst_n  = 1'b1;
    cnt_in = 4'd0;
    repeat (5) tick();
    n_cmp++; if (count_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", count_valid); end
    n_cmp++; if (count_out !== 4'd0)   begin n_fail++; $display("FAIL first_count_out: got %0d want 0", count_out); end
    n_cmp++; if (ext_count !== 12'd0)  begin n_fail++; $display("FAIL first_ext: got %0d want 0", ext_count); end
  endtask

  task automatic test_up_sweep();
    clear_seen();
    cnt_in = 4'd1;
    repeat (4) tick();
    n_cmp++; if (count_out !== 4'd0)   begin n_fail++; $display("FAIL latency_early: got %0d want 0", count_out); end
    tick();
    n_cmp++; if (count_out !== 4'd1)   begin n_fail++; $display("FAIL latency_commit: got %0d want 1", count_out); end
    n_cmp++; if (ext_count !== 12'd1)  begin n_fail++; $display("FAIL latency_ext: got %0d want 1", ext_count); end
    repeat (3) tick();
    for (int v = 2; v <= 15; v++) hold(4'(v), 8);
    hold(4'd0, 8);
    n_cmp++; if (ext_count !== 12'd16) begin n_fail++; $display("FAIL up_ext: got %0d want 16", ext_count); end
    n_cmp++; if (wrap_seen !== 1)      begin n_fail++; $display("FAIL up_wrap_count: got %0d want 1", wrap_seen); end
    n_cmp++; if (wrap_tick !== 5)      begin n_fail++; $display("FAIL up_wrap_edge: got %0d want 5", wrap_tick); end
    n_cmp++; if (err_seen !== 0)       begin n_fail++; $display("FAIL up_err_count: got %0d want 0", err_seen); end
    n_cmp++; if (count_out !== 4'd0)   begin n_fail++; $display("FAIL up_count_out: got %0d want 0", count_out); end
  endtask

  task automatic test_down_sweep();
    logic [3:0]  dv [4];
    logic [11:0] de [4];
    dv = '{4'd2, 4'd1, 4'd0, 4'd15};
    de = '{12'd4095, 12'd4094, 12'd4093, 12'd4092};
    clear_seen();
    clear_and_load(4'd3);
    n_cmp++; if (count_out !== 4'd3)   begin n_fail++; $display("FAIL down_load: got %0d want 3", count_out); end
    n_cmp++; if (ext_count !== 12'd0)  begin n_fail++; $display("FAIL down_load_ext: got %0d want 0", ext_count); end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hold(dv[i], 8);
      n_cmp++;
      if (ext_count !== de[i]) begin
        n_fail++;
        $display("FAIL down_ext_%0d: got %0d want %0d", i, ext_count, de[i]);
      end
    end
    n_cmp++; if (wrap_seen !== 1)      begin n_fail++; $display("FAIL down_wrap_count: got %0d want 1", wrap_seen); end
    n_cmp++; if (err_seen !== 0)       begin n_fail++; $display("FAIL down_err_count: got %0d want 0", err_seen); end
  endtask

  task automatic test_glitch();
    int saw7;
    saw7 = 0;
    up = 1'b1;
    clear_and_load(4'd5);
    clear_seen();
    cnt_in = 4'd7;
    tick();
    cnt_in = 4'd5;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (count_out === 4'd7) saw7 = 1;
      if (wrap)     wrap_seen++;
      if (step_err) err_seen++;
    end
    n_cmp++; if (saw7 !== 0)           begin n_fail++; $display("FAIL glitch_committed: got %0d want 0", saw7); end
    n_cmp++; if (count_out !== 4'd5)   begin n_fail++; $display("FAIL glitch_count_out: got %0d want 5", count_out); end
    n_cmp++; if (err_seen + wrap_seen !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", err_seen + wrap_seen); end
  endtask

  task automatic test_jump();
    up = 1'b1;
    clear_and_load(4'd4);
    clear_seen();
    hold(4'd6, 8);
    n_cmp++; if (err_seen !== 1)       begin n_fail++; $display("FAIL jump_err_count: got %0d want 1", err_seen); end
    n_cmp++; if (err_tick !== 5)       begin n_fail++; $display("FAIL jump_err_edge: got %0d want 5", err_tick); end
    n_cmp++; if (count_out !== 4'd6)   begin n_fail++; $display("FAIL jump_count_out: got %0d want 6", count_out); end
    n_cmp++; if (ext_count !== 12'd0)  begin n_fail++; $display("FAIL jump_ext: got %0d want 0", ext_count); end
    hold(4'd7, 8);
    n_cmp++; if (ext_count !== 12'd1)  begin n_fail++; $display("FAIL jump_next_ext: got %0d want 1", ext_count); end
    n_cmp++; if (err_seen !== 1)       begin n_fail++; $display("FAIL jump_next_err: got %0d want 1", err_seen); end
  endtask

  task automatic test_clr();
    clear_seen();
    for (int v = 8; v <= 15; v++) hold(4'(v), 8);
    hold(4'd0, 8);
    n_cmp++; if (ext_count !== 12'd10) begin n_fail++; $display("FAIL clr_pre_ext: got %0d want 10", ext_count); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (ext_count !== 12'd0)  begin n_fail++; $display("FAIL clr_ext: got %0d want 0", ext_count); end
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", count_valid); end
    tick();
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid_hold: got %b want 0", count_valid); end
    tick();
    n_cmp++; if (count_valid !== 1'b1) begin n_fail++; $display("FAIL clr_recommit: got %b want 1", count_valid); end
    n_cmp++; if (step_err !== 1'b0)    begin n_fail++; $display("FAIL clr_recommit_err: got %b want 0", step_err); end
    hold(4'd1, 8);
    n_cmp++; if (ext_count !== 12'd1)  begin n_fail++; $display("FAIL clr_after_ext: got %0d want 1", ext_count); end
  endtask

  task automatic test_midreset();
    cnt_in = 4'd2;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", count_valid); end
    n_cmp++; if (count_out !== 4'd0)   begin n_fail++; $display("FAIL mid_rst_count_out: got %0d want 0", count_out); end
    n_cmp++; if (ext_count !== 12'd0)  begin n_fail++; $display("FAIL mid_rst_ext: got %0d want 0", ext_count); end
    tick();
    rst_n = 1'b1;
    n_cmp++; if (both_seen !== 0)      begin n_fail++; $display("FAIL wrap_with_err: got %0d want 0", both_seen); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clear_seen();
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_glitch();
    test_jump();
    test_clr();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
